// File: rtl/load_writeback_unit_if.sv
// Bundles the execute-stage handshake, the data-memory read port and the
// register-file write port of load_writeback_unit.
interface load_writeback_unit_if;
  // execute stage
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_alu;
  logic [4:0]  ex_rd;
  // data memory
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  // register file write port and status pulses
  logic [2:0]  rwe;
  logic [31:0] Data_D;
  logic [4:0]  Addr_D;
  logic        bus_err;
  logic        load_misaligned;

  // the writeback unit itself
  modport slave (
    input  ex_valid, ex_op, ex_addr, ex_alu, ex_rd, mem_ready, mem_rdata,
    output ex_ready, mem_req, mem_addr, rwe, Data_D, Addr_D, bus_err,
    load_misaligned
  );

  // execute stage / memory / register-file side
  modport master (
    output ex_valid, ex_op, ex_addr, ex_alu, ex_rd, mem_ready, mem_rdata,
    input  ex_ready, mem_req, mem_addr, rwe, Data_D, Addr_D, bus_err,
    load_misaligned
  );
endinterface

// File: rtl/load_writeback_unit.sv
// load_writeback_unit: accepts one ALU result or load at a time, runs the
// data-memory request/ready handshake for loads, extracts/extends the
// addressed lane and issues a single-cycle register-file write.
// Optional feature macro: LWU_MISALIGN_TRAP_EN (trap misaligned LW/LH/LHU
// instead of forcing the access to alignment).
module load_writeback_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                  clk,
  input logic                  reset,
  load_writeback_unit_if.slave lwu
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_WRITE    = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ALU = 3'd0,
    OP_LW  = 3'd1,
    OP_LH  = 3'd2,
    OP_LB  = 3'd3,
    OP_LHU = 3'd4,
    OP_LBU = 3'd5
  } op_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [2:0]  r_op;
  logic [1:0]  r_off;
  logic [4:0]  r_rd;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [2:0]  r_rwe;
  logic [31:0] r_data;
  logic [4:0]  r_addr;
  logic        r_bus_err;

  logic        w_accept;
  logic        w_is_alu;
  logic        w_is_load;
  logic        w_misaligned;
  logic        w_start_load;
  logic        w_load_done;
  logic        w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_lane_data;
  logic [2:0]  w_lane_rwe;

  assign w_accept    = lwu.ex_valid && (r_state == ST_IDLE);
  assign w_is_alu    = (lwu.ex_op == OP_ALU);
  assign w_is_load   = (lwu.ex_op >= OP_LW) && (lwu.ex_op <= OP_LBU);
  assign w_load_done = (r_state == ST_MEM_WAIT) && lwu.mem_ready;
  assign w_timeout   = (r_state == ST_MEM_WAIT) && !lwu.mem_ready &&
                       (r_cnt == LP_CNT_LAST);

`ifdef LWU_MISALIGN_TRAP_EN
  logic r_misaligned;

  assign w_misaligned = ((lwu.ex_op == OP_LW) && (lwu.ex_addr[1:0] != 2'b00)) ||
                        (((lwu.ex_op == OP_LH) || (lwu.ex_op == OP_LHU)) &&
                         lwu.ex_addr[0]);

  // one-cycle trap pulse in the cycle after a misaligned load is accepted
  always_ff @(posedge clk) begin
    if (!reset) r_misaligned <= 1'b0;
    else        r_misaligned <= w_accept && w_is_load && w_misaligned;
  end

  assign lwu.load_misaligned = r_misaligned;
`else
  // without the trap, low address bits are simply ignored by lane selection
  assign w_misaligned        = 1'b0;
  assign lwu.load_misaligned = 1'b0;
`endif

  assign w_start_load = w_accept && w_is_load && !w_misaligned;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state logic; NOP ops and trapped loads are accepted but stay in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_alu) w_state_nxt = ST_WRITE;
        else if (w_start_load)    w_state_nxt = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        // mem_ready takes priority over an expiring timeout
        if (lwu.mem_ready)               w_state_nxt = ST_WRITE;
        else if (r_cnt == LP_CNT_LAST)   w_state_nxt = ST_IDLE;
      end
      ST_WRITE: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // wait counter: cleared on entry to MEM_WAIT, counts every MEM_WAIT cycle
  always_ff @(posedge clk) begin
    if (!reset)                       r_cnt <= '0;
    else if (w_start_load)            r_cnt <= '0;
    else if (r_state == ST_MEM_WAIT)  r_cnt <= r_cnt + 8'd1;
  end

  // load context and word-aligned memory address captured at acceptance
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op       <= '0;
      r_off      <= '0;
      r_rd       <= '0;
      r_mem_addr <= '0;
    end else if (w_start_load) begin
      r_op       <= lwu.ex_op;
      r_off      <= lwu.ex_addr[1:0];
      r_rd       <= lwu.ex_rd;
      r_mem_addr <= {lwu.ex_addr[31:2], 2'b00};
    end
  end

  // request is high exactly while the FSM sits in MEM_WAIT
  always_ff @(posedge clk) begin
    if (!reset) r_mem_req <= 1'b0;
    else        r_mem_req <= (w_state_nxt == ST_MEM_WAIT);
  end

  // lane extraction and sign/zero extension of the returned word
  always_comb begin
    w_lane_data = lwu.mem_rdata;
    w_lane_rwe  = 3'd1;
    case (r_off)
      2'd0:    w_byte = lwu.mem_rdata[7:0];
      2'd1:    w_byte = lwu.mem_rdata[15:8];
      2'd2:    w_byte = lwu.mem_rdata[23:16];
      default: w_byte = lwu.mem_rdata[31:24];
    endcase
    w_half = r_off[1] ? lwu.mem_rdata[31:16] : lwu.mem_rdata[15:0];
    case (r_op)
      OP_LH:  w_lane_data = {{16{w_half[15]}}, w_half};
      OP_LB:  w_lane_data = {{24{w_byte[7]}}, w_byte};
      OP_LHU: begin
        w_lane_data = {16'h0000, w_half};
        w_lane_rwe  = 3'd4;
      end
      OP_LBU: begin
        w_lane_data = {24'h000000, w_byte};
        w_lane_rwe  = 3'd5;
      end
      default: w_lane_data = lwu.mem_rdata;
    endcase
  end

  // register-file write port: rwe lives for one cycle, data/address hold
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rwe  <= '0;
      r_data <= '0;
      r_addr <= '0;
    end else begin
      r_rwe <= '0;
      if (w_accept && w_is_alu) begin
        r_rwe  <= (lwu.ex_rd != 5'd0) ? 3'd1 : 3'd0;
        r_data <= lwu.ex_alu;
        r_addr <= lwu.ex_rd;
      end else if (w_load_done) begin
        r_rwe  <= (r_rd != 5'd0) ? w_lane_rwe : 3'd0;
        r_data <= w_lane_data;
        r_addr <= r_rd;
      end
    end
  end

  // bus error pulse the cycle after the wait budget runs out
  always_ff @(posedge clk) begin
    if (!reset) r_bus_err <= 1'b0;
    else        r_bus_err <= w_timeout;
  end

  assign lwu.ex_ready = (r_state == ST_IDLE);
  assign lwu.mem_req  = r_mem_req;
  assign lwu.mem_addr = r_mem_addr;
  assign lwu.rwe      = r_rwe;
  assign lwu.Data_D   = r_data;
  assign lwu.Addr_D   = r_addr;
  assign lwu.bus_err  = r_bus_err;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Self-checking bench for load_writeback_unit: directed cases followed by
// randomized operations checked against a transaction-level model.
module tb_load_writeback_unit;

  localparam int unsigned TMO = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  load_writeback_unit_if bus ();

  load_writeback_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .lwu   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: misalignment trap rule
  function automatic bit model_trap(input logic [2:0] op, input logic [31:0] addr);
`ifdef LWU_MISALIGN_TRAP_EN
    return (op == 3'd1 && (addr % 4) != 0) ||
           ((op == 3'd2 || op == 3'd4) && (addr % 2) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // reference model: value and write code for a completed load
  task automatic model_load(input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] word, input logic [4:0] rd,
                            output logic [31:0] data, output logic [2:0] code);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (8 * (addr % 4))) & 32'hFF;
    h = (word >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
    case (op)
      3'd2: begin data = (h >= 32'h8000) ? h + 32'hFFFF0000 : h; code = 3'd1; end
      3'd3: begin data = (b >= 32'h80) ? b + 32'hFFFFFF00 : b;   code = 3'd1; end
      3'd4: begin data = h; code = 3'd4; end
      3'd5: begin data = b; code = 3'd5; end
      default: begin data = word; code = 3'd1; end
    endcase
    if (rd == 5'd0) code = 3'd0;
  endtask

  task automatic check_reset_values(input string pfx);
    check_val({pfx, "_rwe"},    bus.rwe, 0);
    check_val({pfx, "_data"},   bus.Data_D, 0);
    check_val({pfx, "_addrd"},  bus.Addr_D, 0);
    check_val({pfx, "_req"},    bus.mem_req, 0);
    check_val({pfx, "_maddr"},  bus.mem_addr, 0);
    check_val({pfx, "_berr"},   bus.bus_err, 0);
    check_val({pfx, "_misal"},  bus.load_misaligned, 0);
    check_val({pfx, "_ready"},  bus.ex_ready, 1);
  endtask

  // present one operation; delay = MEM_WAIT cycles before mem_ready
  task automatic do_op(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] alu, input logic [4:0] rd,
                       input logic [31:0] rdata, input int unsigned delay);
    logic [31:0] exp_d;
    logic [2:0]  exp_rwe;
    bit          done;
    @(negedge clk);
    check_val("idle_ready", bus.ex_ready, 1);
    bus.ex_valid  = 1'b1;
    bus.ex_op     = op;
    bus.ex_addr   = addr;
    bus.ex_alu    = alu;
    bus.ex_rd     = rd;
    bus.mem_ready = 1'($urandom % 2);
    bus.mem_rdata = $urandom;
    @(posedge clk);
    #1;
    bus.ex_valid  = 1'b0;
    bus.ex_op     = 3'($urandom);
    bus.ex_addr   = $urandom;
    bus.ex_alu    = $urandom;
    bus.ex_rd     = 5'($urandom);
    bus.mem_ready = 1'b0;
    if (op >= 3'd6) begin
      @(negedge clk);
      check_val("nop_rwe", bus.rwe, 0);
      check_val("nop_req", bus.mem_req, 0);
      check_val("nop_ready", bus.ex_ready, 1);
    end else if (op == 3'd0) begin
      @(negedge clk);
      check_val("alu_rwe", bus.rwe, (rd != 0) ? 1 : 0);
      check_val("alu_data", bus.Data_D, alu);
      check_val("alu_rd", bus.Addr_D, rd);
      check_val("alu_busy", bus.ex_ready, 0);
      @(negedge clk);
      check_val("alu_rwe_clr", bus.rwe, 0);
    end else if (model_trap(op, addr)) begin
      @(negedge clk);
      check_val("trap_pulse", bus.load_misaligned, 1);
      check_val("trap_req", bus.mem_req, 0);
      check_val("trap_rwe", bus.rwe, 0);
      check_val("trap_ready", bus.ex_ready, 1);
      @(negedge clk);
      check_val("trap_clr", bus.load_misaligned, 0);
      check_val("trap_rwe2", bus.rwe, 0);
    end else begin
      model_load(op, addr, rdata, rd, exp_d, exp_rwe);
      done = 1'b0;
      for (int unsigned k = 0; k < TMO && !done; k++) begin
        @(negedge clk);
        check_val("wait_req", bus.mem_req, 1);
        check_val("wait_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
        check_val("wait_busy", bus.ex_ready, 0);
        if (k == delay) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rdata;
          done = 1'b1;
        end else begin
          bus.mem_rdata = $urandom;
        end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
      end
      @(negedge clk);
      if (done) begin
        check_val("ld_rwe", bus.rwe, exp_rwe);
        check_val("ld_data", bus.Data_D, exp_d);
        check_val("ld_rd", bus.Addr_D, rd);
        check_val("ld_req_drop", bus.mem_req, 0);
        check_val("ld_no_berr", bus.bus_err, 0);
        check_val("ld_busy", bus.ex_ready, 0);
        @(negedge clk);
        check_val("ld_rwe_clr", bus.rwe, 0);
      end else begin
        check_val("tmo_berr", bus.bus_err, 1);
        check_val("tmo_req", bus.mem_req, 0);
        check_val("tmo_rwe", bus.rwe, 0);
        check_val("tmo_ready", bus.ex_ready, 1);
        @(negedge clk);
        check_val("tmo_berr_clr", bus.bus_err, 0);
        check_val("tmo_rwe2", bus.rwe, 0);
      end
    end
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [4:0]  r_rd;
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b0;
    bus.ex_valid  = 1'b0;
    bus.ex_op     = '0;
    bus.ex_addr   = '0;
    bus.ex_alu    = '0;
    bus.ex_rd     = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    reset = 1'b1;

    // directed cases
    do_op(3'd0, 32'h0, 32'hDEADBEEF, 5'd7, 32'h0, 0);
    do_op(3'd3, 32'h103, 32'h0, 5'd9, 32'h80FF_0000, 3);
    do_op(3'd5, 32'h103, 32'h0, 5'd9, 32'h80FF_0000, 1);
    do_op(3'd2, 32'h202, 32'h0, 5'd3, 32'h7FFE_1234, 0);
    do_op(3'd4, 32'h202, 32'h0, 5'd3, 32'h8001_0000, 2);
    do_op(3'd1, 32'h300, 32'h0, 5'd4, 32'h1234_5678, TMO + 5);
    do_op(3'd1, 32'h304, 32'h0, 5'd4, 32'hCAFE_F00D, TMO - 1);
    do_op(3'd1, 32'h400, 32'h0, 5'd0, 32'h1111_2222, 1);
    do_op(3'd1, 32'h101, 32'h0, 5'd6, 32'hA5A5_5A5A, 0);
    do_op(3'd4, 32'h203, 32'h0, 5'd6, 32'hF00D_8123, 0);
    do_op(3'd7, 32'h0, 32'h5555_5555, 5'd1, 32'h0, 0);

    // reset during MEM_WAIT abandons the load
    @(negedge clk);
    bus.ex_valid = 1'b1;
    bus.ex_op    = 3'd1;
    bus.ex_addr  = 32'h0000_0808;
    bus.ex_rd    = 5'd5;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    @(negedge clk);
    check_val("rstmid_req", bus.mem_req, 1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("rstmid");
    reset = 1'b1;

    // randomized operations
    for (int i = 0; i < 300; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_rd = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
      do_op(r_op, $urandom, $urandom, r_rd, $urandom,
            $urandom_range(0, TMO + 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_writeback_unit.md
# load_writeback_unit

Multi-cycle load and writeback sequencer between the execute stage and the 32×32 register file. Accepts one ALU result or load operation at a time and runs the data-memory request/ready handshake for loads. Extracts and extends the addressed byte or halfword, then drives the register file's write port (`rwe`, `Data_D`, `Addr_D`) for exactly one cycle per completed operation.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum cycles spent waiting for `mem_ready` before a bus error is raised (range 1..255).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0, sampled on rising `clk`).
- `ex_valid`  in  1  execute stage presents an operation.
- `ex_ready`  out  1  block accepts an operation; a transfer happens when `ex_valid && ex_ready`.
- `ex_op`  in  3  0 = ALU writeback, 1 = LW, 2 = LH, 3 = LB, 4 = LHU, 5 = LBU; 6 and 7 are treated as NOP.
- `ex_addr`  in  32  load byte address.
- `ex_alu`  in  32  ALU result, used for op 0 only.
- `ex_rd`  in  5  destination register.
- `mem_req`  out  1  read request to data memory.
- `mem_addr`  out  32  word-aligned read address, `{ex_addr[31:2], 2'b00}`.
- `mem_ready`  in  1  `mem_rdata` is valid in this cycle.
- `mem_rdata`  in  32  read word, little-endian.
- `rwe`  out  3  register-file write code: 0 = none, 1 = full write, 4 = lhu, 5 = lbu.
- `Data_D`  out  32  write data.
- `Addr_D`  out  5  write address.
- `bus_err`  out  1  one-cycle pulse when a load times out.
- `load_misaligned`  out  1  one-cycle pulse when a misaligned load is detected (only with the macro below).

## Operation
- FSM states: IDLE, MEM_WAIT, WRITE.
- IDLE
  - `ex_ready` = 1; this is combinational and equals (state == IDLE).
  - On an op 0 transfer: latch `ex_alu` and `ex_rd` → WRITE.
  - On a load transfer: latch op, `ex_addr[1:0]` and `ex_rd`; register `mem_addr`; set `mem_req` = 1 → MEM_WAIT.
  - On a NOP op: the transfer is accepted; the state stays IDLE and no write occurs.
- MEM_WAIT
  - `mem_req` is held at 1 and the timeout counter increments every cycle.
  - On `mem_ready`: capture the lane, clear `mem_req` → WRITE.
  - When the counter reaches `TIMEOUT_CYCLES` without `mem_ready`: pulse `bus_err`, clear `mem_req`, perform no write → IDLE.
- WRITE: the registered outputs `rwe`, `Data_D` and `Addr_D` are valid for this one cycle → IDLE.
- Lane extraction uses offset `off = addr[1:0]`:
  - LW: `Data_D` = word, `rwe` = 1.
  - LH: halfword = `rdata[16*off[1] +: 16]`, sign-extended to 32 bits, `rwe` = 1.
  - LB: byte = `rdata[8*off +: 8]`, sign-extended, `rwe` = 1.
  - LHU: same halfword, zero-extended, `rwe` = 4.
  - LBU: same byte, zero-extended, `rwe` = 5.
  - Signed loads are always extended here. Codes 2 and 3 are never emitted.
- If `rd` == 0, WRITE is still entered but `rwe` = 0.
- `rwe` is 0 in every cycle outside WRITE. `Data_D` and `Addr_D` hold their last values.

## Timing
- Reset values: `rwe` = 0, `Data_D` = 0, `Addr_D` = 0, `mem_req` = 0, `mem_addr` = 0, `bus_err` = 0, `load_misaligned` = 0, state = IDLE (so `ex_ready` = 1), counter = 0.
- ALU op latency: accept at edge N, `rwe` valid in cycle N+1; the next op can be accepted in cycle N+2.
- Load latency:
  - Accept at edge N; `mem_req` = 1 from cycle N+1.
  - `mem_ready` sampled at edge M; `rwe` valid in cycle M+1.
  - `mem_ready` in the first MEM_WAIT cycle gives a minimum load latency of 2 cycles from acceptance to write.
- `mem_ready` is ignored whenever the state is not MEM_WAIT.
- `mem_addr` is stable for as long as `mem_req` = 1.
- `mem_ready` arriving in the same cycle the counter hits the limit: `mem_ready` wins and no `bus_err` is raised.
- Reset asserted mid-operation: the operation is abandoned with no write. `mem_req` drops at that edge.
- The counter clears on entry to MEM_WAIT.

## Configuration
- `LWU_MISALIGN_TRAP_EN` defined:
  - LW with `addr[1:0]` ≠ 0, or LH/LHU with `addr[0]` = 1, issues no memory request.
  - `load_misaligned` pulses in the cycle after acceptance, and the state returns to IDLE with no write.
- Not defined:
  - `load_misaligned` is tied to 0.
  - LW ignores `addr[1:0]`; LH/LHU ignore `addr[0]`, i.e. the access is forced to alignment.

## Test plan
- ALU op (0), `ex_alu` = 0xDEADBEEF, rd = 7 → in the next cycle `rwe` = 1, `Data_D` = 0xDEADBEEF, `Addr_D` = 7 for one cycle.
- LB, addr = 0x103, `mem_rdata` = 0x80FF_0000, `mem_ready` after 3 cycles → `mem_addr` = 0x100, `Data_D` = 0xFFFFFF80, `rwe` = 1; LBU on the same data → `Data_D` = 0x00000080, `rwe` = 5.
- LH, addr = 0x202, `mem_rdata` = 0x7FFE_1234 → `Data_D` = 0x00007FFE, `rwe` = 1; LHU with rdata 0x8001_0000 → `Data_D` = 0x00008001, `rwe` = 4.
- LW with `mem_ready` held low and `TIMEOUT_CYCLES` = 4 → `bus_err` pulses once, `mem_req` drops, `rwe` stays 0, `ex_ready` returns to 1.
- LW to rd = 0 → handshake completes and `rwe` = 0. Reset driven low during MEM_WAIT → `mem_req` = 0 and all outputs at reset values in the next cycle.
- With `LWU_MISALIGN_TRAP_EN` defined: LW at addr 0x101 → no `mem_req`, `load_misaligned` = 1 for one cycle, no write. Without the macro: the same stimulus reads 0x100 and writes the full word.
